// File: rtl/axi_ni_receive_flit_controller.sv
// axi_ni_receive_flit_controller: sequences incoming NoC flits into header/payload capture strobes
// and holds a completed (or malformed) packet until the consumer takes it.
module axi_ni_receive_flit_controller #(
    parameter int FLIT_WIDTH        = 32,
    parameter int FTYPE_WIDTH       = 2,
    parameter int HEADER_FLITS      = 2,
    parameter int MAX_PAYLOAD_FLITS = 8,
    parameter int CNT_WIDTH         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] flit_in,
    input  logic                  flit_valid,
    output logic                  flit_ready,
    output logic                  sample_header,
    output logic                  sample_payload,
    output logic [CNT_WIDTH-1:0]  flit_count,
    output logic [CNT_WIDTH-1:0]  payload_flits,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic                  pkt_error
);
    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, DROP, PENDING} state_t;
    localparam logic [FTYPE_WIDTH-1:0] T_HEAD = FTYPE_WIDTH'(1);
    localparam logic [FTYPE_WIDTH-1:0] T_TAIL = FTYPE_WIDTH'(2);
    localparam logic [FTYPE_WIDTH-1:0] T_HT   = FTYPE_WIDTH'(3);
    localparam logic [2:0]             HDR_LAST = 3'(HEADER_FLITS - 1);
    localparam logic [CNT_WIDTH-1:0]   PAY_MAX  = CNT_WIDTH'(MAX_PAYLOAD_FLITS);

    state_t                 state_q, state_d;
    logic [2:0]             hdr_q, hdr_d;
    logic [CNT_WIDTH-1:0]   payload_q, payload_d;
    logic                   err_q, err_d;
    logic [FTYPE_WIDTH-1:0] ftype;
    logic                   accept, is_tail, is_ht, starts, ends, full, hdr_last;
    logic                   unused_flit_bits;

    assign ftype            = flit_in[FTYPE_WIDTH-1:0];
    assign unused_flit_bits = ^flit_in[FLIT_WIDTH-1:FTYPE_WIDTH];
    assign is_tail          = ftype == T_TAIL;
    assign is_ht            = ftype == T_HT;
    assign starts           = ftype == T_HEAD || is_ht;
    assign ends             = is_tail || is_ht;
    assign full             = payload_q == PAY_MAX;
    assign hdr_last         = hdr_q == HDR_LAST;
    assign accept           = flit_valid && flit_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hdr_q     <= '0;
            payload_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            payload_q <= payload_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        payload_d = payload_q;
        err_d     = err_q;
        case (state_q)
            IDLE: if (accept && starts) begin
                hdr_d   = 3'd1;
                err_d   = is_ht && HEADER_FLITS != 1;
                state_d = is_ht ? PENDING : (HEADER_FLITS == 1 ? PAYLOAD : HEADER);
            end
            HEADER: if (accept) begin
                if (starts) begin
                    err_d   = 1'b1;
                    state_d = is_ht ? PENDING : DROP;
                end else if (is_tail) begin
                    // a packet ending inside its header has no payload phase at all
                    err_d   = 1'b1;
                    state_d = PENDING;
                end else begin
                    hdr_d   = hdr_last ? hdr_q : hdr_q + 3'd1;
                    state_d = hdr_last ? PAYLOAD : HEADER;
                end
            end
            PAYLOAD: if (accept) begin
                if (starts) begin
                    err_d   = 1'b1;
                    state_d = is_ht ? PENDING : DROP;
                end else begin
                    payload_d = full ? payload_q : payload_q + CNT_WIDTH'(1);
                    err_d     = err_q || full;
                    state_d   = is_tail ? PENDING : (full ? DROP : PAYLOAD);
                end
            end
            DROP: if (accept && ends) state_d = PENDING;
            PENDING: if (pkt_ready) begin
                state_d   = IDLE;
                hdr_d     = '0;
                payload_d = '0;
                err_d     = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flit_ready     = !rst && state_q != PENDING;
        sample_header  = accept && ((state_q == IDLE && starts) || (state_q == HEADER && !starts));
        sample_payload = accept && state_q == PAYLOAD && !starts && !full;
        flit_count     = rst ? '0 : state_q == HEADER ? CNT_WIDTH'(hdr_q) :
                         state_q == PAYLOAD ? payload_q : '0;
        payload_flits  = rst ? '0 : payload_q;
        pkt_valid      = !rst && state_q == PENDING;
        pkt_error      = !rst && err_q;
    end
endmodule

// File: tb/tb_axi_ni_receive_flit_controller.sv
// tb_axi_ni_receive_flit_controller: directed and randomized checks against a packet-rule reference model.
module tb_axi_ni_receive_flit_controller;
    localparam int CW   = 4;
    localparam int MAXP = 8;
    localparam int HF   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flit_valid = 1'b0;
    logic          pkt_ready = 1'b0;
    logic [31:0]   flit_in = '0;
    logic          fr0, sh0, sp0, pv0, pe0, fr1, sh1, sp1, pv1, pe1;
    logic [CW-1:0] fc0, pf0, fc1, pf1;
    int            n_chk = 0;
    int            n_fail = 0;
    int            sp_pulses = 0;
    bit            m_started, m_drop, m_err, m_done;
    int            m_hdr, m_pay;

    axi_ni_receive_flit_controller u0 (
        .clk(clk), .rst(rst), .flit_in(flit_in), .flit_valid(flit_valid), .flit_ready(fr0),
        .sample_header(sh0), .sample_payload(sp0), .flit_count(fc0), .payload_flits(pf0),
        .pkt_valid(pv0), .pkt_ready(pkt_ready), .pkt_error(pe0)
    );

    axi_ni_receive_flit_controller #(.HEADER_FLITS(1)) u1 (
        .clk(clk), .rst(rst), .flit_in(flit_in), .flit_valid(flit_valid), .flit_ready(fr1),
        .sample_header(sh1), .sample_payload(sp1), .flit_count(fc1), .payload_flits(pf1),
        .pkt_valid(pv1), .pkt_ready(pkt_ready), .pkt_error(pe1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic m_clear;
        m_started = 0; m_drop = 0; m_err = 0; m_done = 0; m_hdr = 0; m_pay = 0;
    endtask

    // Packet rules for the default configuration, tracked as counts of flits seen per phase.
    task automatic m_step(input logic [1:0] ty, output bit sh, output bit sp, output int cnt);
        bit hd, tl, ht;
        hd = ty == 2'b01; tl = ty == 2'b10; ht = ty == 2'b11;
        sh = 0; sp = 0; cnt = 0;
        if (!m_started) begin
            if (hd || ht) begin
                sh = 1; m_started = 1; m_hdr = 1;
                if (ht) begin m_done = 1; m_err = HF != 1; end
            end
        end else if (m_drop) m_done = tl || ht;
        else if (hd || ht) begin m_err = 1; m_drop = hd; m_done = ht; end
        else if (m_hdr < HF) begin
            sh = 1; cnt = m_hdr; m_hdr++;
            if (tl) begin m_err = 1; m_done = 1; end
        end else begin
            if (m_pay < MAXP) begin sp = 1; cnt = m_pay; m_pay++; end
            else begin m_err = 1; m_drop = !tl; end
            m_done = tl;
        end
    endtask

    task automatic send(input logic [1:0] ty);
        bit sh, sp;
        int cnt;
        @(negedge clk);
        flit_valid = 1'b1;
        flit_in = $urandom;
        flit_in[1:0] = ty;
        m_step(ty, sh, sp, cnt);
        #1;
        n_chk++;
        if (fr0 !== 1'b1 || sh0 !== sh || sp0 !== sp || ((sh || sp) && fc0 !== CW'(cnt))) begin
            n_fail++;
            $display("FAIL send type=%b: ready=%b hdr=%b pay=%b cnt=%0d, want ready=1 hdr=%b pay=%b cnt=%0d",
                     ty, fr0, sh0, sp0, fc0, sh, sp, cnt);
        end
        sp_pulses += int'(sp0);
        @(posedge clk);
    endtask

    task automatic release_pkt;
        @(negedge clk);
        flit_valid = 1'b0;
        pkt_ready = 1'b1;
        @(posedge clk);
        #1 pkt_ready = 1'b0;
        m_clear();
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; flit_valid = 1'b0; pkt_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_clear();
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; flit_valid = 1'b1; flit_in = 32'h1; pkt_ready = 1'b0;
        #1;
        n_chk++;
        if ({fr0, sh0, sp0} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: ready/hdr/pay=%b want 000", {fr0, sh0, sp0});
        end
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({pv0, pe0, pf0, fc0} !== '0) begin
            n_fail++; $display("FAIL reset_state: valid=%b err=%b pay=%0d cnt=%0d want all 0", pv0, pe0, pf0, fc0);
        end
        rst = 1'b0; flit_valid = 1'b0;
        m_clear();
    endtask

    task automatic test_basic;
        logic [1:0] seq [6] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        do_reset();
        foreach (seq[i]) send(seq[i]);
        @(negedge clk);
        flit_valid = 1'b0;
        #1;
        n_chk++;
        if ({pv0, pe0, pf0} !== {1'b1, 1'b0, 4'd4}) begin
            n_fail++; $display("FAIL basic_pkt: valid=%b err=%b pay=%0d want 1 0 4", pv0, pe0, pf0);
        end
    endtask

    task automatic test_pending;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            flit_valid = 1'b1;
            flit_in = $urandom;
            flit_in[1:0] = 2'b01;
            #1;
            n_chk++;
            if ({fr0, sh0, sp0} !== 3'b000 || {pv0, pe0, pf0} !== {1'b1, 1'b0, 4'd4}) begin
                n_fail++;
                $display("FAIL pending_hold: ready=%b hdr=%b pay=%b valid=%b err=%b pf=%0d want 0 0 0 1 0 4",
                         fr0, sh0, sp0, pv0, pe0, pf0);
            end
        end
        release_pkt();
        send(2'b01);
    endtask

    task automatic test_overflow;
        do_reset();
        sp_pulses = 0;
        send(2'b01);
        send(2'b00);
        repeat (9) send(2'b00);
        send(2'b10);
        @(negedge clk);
        flit_valid = 1'b0;
        #1;
        n_chk++;
        if (sp_pulses != 8 || {pv0, pe0, pf0} !== {1'b1, 1'b1, 4'd8}) begin
            n_fail++;
            $display("FAIL overflow: pulses=%0d valid=%b err=%b pay=%0d want 8 1 1 8", sp_pulses, pv0, pe0, pf0);
        end
    endtask

    task automatic test_hdr_err;
        do_reset();
        send(2'b01);
        send(2'b10);
        @(negedge clk);
        flit_valid = 1'b0;
        #1;
        n_chk++;
        if ({pv0, pe0, pf0} !== {1'b1, 1'b1, 4'd0} || {pv1, pe1, pf1} !== {1'b1, 1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL short_header: hf2 %b/%b/%0d want 1/1/0, hf1 %b/%b/%0d want 1/0/1",
                     pv0, pe0, pf0, pv1, pe1, pf1);
        end
        release_pkt();
        send(2'b11);
        @(negedge clk);
        flit_valid = 1'b0;
        #1;
        n_chk++;
        if ({pv0, pe0, pf0} !== {1'b1, 1'b1, 4'd0} || {pv1, pe1, pf1} !== {1'b1, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL head_tail: hf2 %b/%b/%0d want 1/1/0, hf1 %b/%b/%0d want 1/0/0",
                     pv0, pe0, pf0, pv1, pe1, pf1);
        end
        release_pkt();
    endtask

    task automatic test_rst_mid;
        bit sh, sp;
        int cnt;
        do_reset();
        send(2'b01); send(2'b00); send(2'b00); send(2'b00);
        @(negedge clk);
        rst = 1'b1; flit_valid = 1'b1; flit_in = 32'h5;
        #1;
        n_chk++;
        if ({fr0, sh0, sp0} !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_strobes: ready/hdr/pay=%b want 000", {fr0, sh0, sp0});
        end
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({pv0, pe0, pf0, fc0} !== '0) begin
            n_fail++; $display("FAIL rst_mid_state: valid=%b err=%b pay=%0d cnt=%0d want all 0", pv0, pe0, pf0, fc0);
        end
        rst = 1'b0;
        flit_in = 32'hA5A5_0001;
        m_clear();
        m_step(2'b01, sh, sp, cnt);
        #1;
        n_chk++;
        if ({fr0, sh0, sp0} !== 3'b110 || fc0 !== 4'd0) begin
            n_fail++; $display("FAIL rst_release_accept: ready/hdr/pay=%b cnt=%0d want 110 0", {fr0, sh0, sp0}, fc0);
        end
        @(posedge clk);
        send(2'b00); send(2'b00); send(2'b10);
        @(negedge clk);
        flit_valid = 1'b0;
        #1;
        n_chk++;
        if ({pv0, pe0, pf0} !== {1'b1, 1'b0, 4'd2}) begin
            n_fail++; $display("FAIL rst_mid_next_pkt: valid=%b err=%b pay=%0d want 1 0 2", pv0, pe0, pf0);
        end
        release_pkt();
    endtask

    task automatic test_protocol;
        do_reset();
        send(2'b00);
        send(2'b01); send(2'b00); send(2'b00);
        send(2'b01);
        send(2'b00); send(2'b00); send(2'b10);
        @(negedge clk);
        flit_valid = 1'b0;
        #1;
        n_chk++;
        if ({pv0, pe0, pf0} !== {1'b1, 1'b1, 4'd1}) begin
            n_fail++; $display("FAIL protocol_err: valid=%b err=%b pay=%0d want 1 1 1", pv0, pe0, pf0);
        end
        release_pkt();
    endtask

    task automatic test_random;
        do_reset();
        for (int p = 0; p < 40; p++) begin
            int n = 0;
            while (!m_done) begin
                logic [1:0] ty;
                int r;
                r = $urandom_range(0, 99);
                if (n >= 30) ty = m_started ? 2'b10 : 2'b01;
                else if (!m_started) ty = r < 80 ? 2'b01 : r < 90 ? 2'b11 : r < 95 ? 2'b00 : 2'b10;
                else ty = r < 65 ? 2'b00 : r < 85 ? 2'b10 : r < 93 ? 2'b01 : 2'b11;
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    flit_valid = 1'b0;
                end
                send(ty);
                n++;
            end
            @(negedge clk);
            flit_valid = 1'b0;
            #1;
            n_chk++;
            if ({pv0, pe0, pf0} !== {1'b1, m_err, CW'(m_pay)}) begin
                n_fail++;
                $display("FAIL random_pkt %0d: valid=%b err=%b pay=%0d want 1 %b %0d", p, pv0, pe0, pf0, m_err, m_pay);
            end
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                flit_valid = 1'b1;
                flit_in = $urandom;
                #1;
                n_chk++;
                if ({fr0, sh0, sp0, pv0} !== 4'b0001) begin
                    n_fail++; $display("FAIL random_hold %0d: ready/hdr/pay/valid=%b want 0001", p, {fr0, sh0, sp0, pv0});
                end
            end
            release_pkt();
        end
    endtask

    initial begin
        m_clear();
        test_reset();
        test_basic();
        test_pending();
        test_overflow();
        test_hdr_err();
        test_rst_mid();
        test_protocol();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_ni_receive_flit_controller.md
AXI_NI_RECEIVE_FLIT_CONTROLLER -- requirements
Module: axi_ni_receive_flit_controller

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 32, flit width in bits.
REQ-002 SHALL have parameter FTYPE_WIDTH, default 2, flit-type field width, located at flit_in[FTYPE_WIDTH-1:0].
REQ-003 SHALL have parameter HEADER_FLITS, default 2, header flits per packet (range 1..8).
REQ-004 SHALL have parameter MAX_PAYLOAD_FLITS, default 8, payload flit capacity.
REQ-005 SHALL have parameter CNT_WIDTH, default 4, counter width; must satisfy 2^CNT_WIDTH > MAX_PAYLOAD_FLITS.
REQ-006 SHALL have port clk, input, 1 bit, clock; all state updates on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-008 SHALL have port flit_in, input, FLIT_WIDTH bits, incoming flit.
REQ-009 SHALL have port flit_valid, input, 1 bit, flit_in valid.
REQ-010 SHALL have port flit_ready, output, 1 bit, flit accept.
REQ-011 SHALL have port sample_header, output, 1 bit, capture current flit into header register.
REQ-012 SHALL have port sample_payload, output, 1 bit, capture current flit into payload register.
REQ-013 SHALL have port flit_count, output, CNT_WIDTH bits, index of current flit within its phase (header or payload).
REQ-014 SHALL have port payload_flits, output, CNT_WIDTH bits, payload flits stored in current packet.
REQ-015 SHALL have port pkt_valid, output, 1 bit, complete packet available.
REQ-016 SHALL have port pkt_ready, input, 1 bit, consumer has taken packet.
REQ-017 SHALL have port pkt_error, output, 1 bit, packet malformed; valid while pkt_valid.

Function
REQ-018 Flit types SHALL be: 2'b00 body, 2'b01 head, 2'b10 tail, 2'b11 head+tail.
REQ-019 Accept SHALL mean flit_valid && flit_ready in the same cycle.
REQ-020 FSM states SHALL be IDLE, HEADER, PAYLOAD, DROP, PENDING.
REQ-021 flit_ready SHALL be 1 in IDLE, HEADER, PAYLOAD and DROP; 0 in PENDING and while rst is high.
REQ-022 sample_header and sample_payload SHALL be combinational, asserted only in an accept cycle, so the downstream register captures on the same edge (zero latency).
REQ-023 IDLE: accepted head or head+tail flit -> sample_header=1, flit_count=0; non-head flit -> accepted and discarded, no sample, stay IDLE.
REQ-024 IDLE head (01): HEADER_FLITS=1 -> PAYLOAD, else -> HEADER with header index 1.
REQ-025 IDLE head+tail (11): HEADER_FLITS=1 -> PENDING with pkt_error=0, else -> PENDING with pkt_error=1.
REQ-026 HEADER: each accepted flit -> sample_header=1, flit_count=header index; last header index -> PAYLOAD with flit_count cleared; tail/head+tail before last index -> PENDING with pkt_error=1.
REQ-027 PAYLOAD: accepted flit with payload_flits < MAX_PAYLOAD_FLITS -> sample_payload=1, flit_count=payload_flits, payload_flits increments next cycle; tail type -> PENDING.
REQ-028 PAYLOAD overflow (payload_flits == MAX_PAYLOAD_FLITS): no sample, pkt_error set; tail -> PENDING, else -> DROP.
REQ-029 Head or head+tail flit arriving in HEADER or PAYLOAD SHALL be treated as protocol error: not sampled, pkt_error set, -> DROP (head) or PENDING (head+tail).
REQ-030 DROP: accept and discard flits until tail or head+tail, then -> PENDING.
REQ-031 PENDING: pkt_valid=1, held with pkt_error and payload_flits stable until pkt_ready=1; on that edge -> IDLE, pkt_error, payload_flits, flit_count cleared.
REQ-032 pkt_ready while pkt_valid=0 SHALL be ignored.
REQ-033 Counters SHALL never wrap; payload_flits saturates at MAX_PAYLOAD_FLITS.

Reset
REQ-034 rst high SHALL force IDLE, pkt_valid=0, pkt_error=0, payload_flits=0, flit_count=0, flit_ready=0, sample_*=0, regardless of state including mid-packet and PENDING.
REQ-035 First flit after rst deasserts SHALL be acceptable in that same cycle.

Verification
REQ-036 Defaults; head, header body, 3 body, tail back-to-back -> sample_header at counts 0,1; sample_payload at counts 0..3; pkt_valid next cycle, payload_flits=4, pkt_error=0.
REQ-037 Packet of 2 header + 10 payload flits -> 8 sample_payload pulses, pkt_error=1, payload_flits=8, pkt_valid after tail.
REQ-038 pkt_ready held low 5 cycles with flit_valid high -> flit_ready=0, no samples, outputs stable; pkt_ready=1 -> IDLE, next head accepted following cycle.
REQ-039 head then tail (HEADER_FLITS=2) -> pkt_valid with pkt_error=1, payload_flits=0; HEADER_FLITS=1 head+tail -> pkt_error=0.
REQ-040 rst asserted mid-PAYLOAD after 2 flits -> all outputs cleared next cycle; next packet starts at flit_count=0 error-free.
REQ-041 body flit in IDLE, then head in PAYLOAD -> first discarded silently; second sets pkt_error, DROP until tail.
